// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running 0..DIV-1 divider; tick is high in the cycle the count is DIV-1.
module uart_baud_tick #(
    parameter int unsigned DIV = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        if (clear) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multi_byte_uart_tx.sv
// Sends NUM_BYTES bytes MSB-byte first as back-to-back 8N1/8N2 frames.
// Optional even parity bit per frame when UART_TX_PARITY_EN is defined.
module multi_byte_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned BAUD      = 9600,
    parameter int unsigned NUM_BYTES = 2,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                start,
    input  logic [UART_DATA_BITS*NUM_BYTES-1:0] data,
    output logic                                ready,
    output logic                                done,
    output logic                                q
);

    localparam int unsigned DIV = baud_div(CLK_HZ, BAUD);
    localparam int unsigned W   = UART_DATA_BITS * NUM_BYTES;
    localparam int unsigned IW  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    if (DIV < 2) begin : g_div_check
        $error("multi_byte_uart_tx: CLK_HZ/BAUD must be at least 2");
    end
    if (NUM_BYTES < 1 || NUM_BYTES > 16) begin : g_bytes_check
        $error("multi_byte_uart_tx: NUM_BYTES must be 1..16");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
        $error("multi_byte_uart_tx: STOP_BITS must be 1 or 2");
    end

    tx_state_t     state_q, state_d;
    logic [W-1:0]  shift_q, shift_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [IW-1:0] byte_idx_q, byte_idx_d;
    logic          line_q, line_d;
    logic          accept;
    logic          tick;
    logic [7:0]    cur_byte;
    logic          last_byte;
    logic          last_stop;

    uart_baud_tick #(
        .DIV(DIV)
    ) u_baud (
        .clock(clock),
        .reset(reset),
        .clear(accept),
        .tick (tick)
    );

    assign cur_byte  = shift_q[W-1 -: UART_DATA_BITS];
    assign last_byte = (byte_idx_q == IW'(NUM_BYTES - 1));
    assign last_stop = (bit_idx_q == 3'(STOP_BITS - 1));

    // line_d always holds the value for the state being entered, so q is
    // a plain register yet changes in the same cycle as the state.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        line_d     = line_q;
        accept     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_d    = START;
                    shift_d    = data;
                    byte_idx_d = '0;
                    bit_idx_d  = '0;
                    line_d     = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    line_d    = cur_byte[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
                        line_d    = ^cur_byte;
`else
                        state_d   = STOP;
                        line_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        line_d    = cur_byte[bit_idx_d];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    line_d  = 1'b1;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (last_stop) begin
                        bit_idx_d = '0;
                        if (last_byte) begin
                            state_d = IDLE;
                        end else begin
                            state_d    = START;
                            byte_idx_d = byte_idx_q + IW'(1);
                            shift_d    = shift_q << UART_DATA_BITS;
                            line_d     = 1'b0;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                line_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            line_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            line_q     <= line_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign done  = (state_q == STOP) && tick && last_stop && last_byte;
    assign q     = line_q;

endmodule

// File: tb/tb_multi_byte_uart_tx.sv
// Scoreboard bench: two DUT configurations (2 bytes/1 stop, 1 byte/2 stop), DIV=8.
`timescale 1ns/1ps
module tb_multi_byte_uart_tx;

    localparam int unsigned DIV = 8;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned DONE_A = 176;
    localparam int unsigned DONE_B = 96;
    localparam bit          PAR_ON = 1'b1;
`else
    localparam int unsigned DONE_A = 160;
    localparam int unsigned DONE_B = 88;
    localparam bit          PAR_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start_a, start_b;
    logic [15:0] data_a;
    logic [7:0]  data_b;
    logic        ready_a, done_a, q_a;
    logic        ready_b, done_b, q_b;

    int checks = 0;
    int errors = 0;

    bit          bq_a[$];
    bit          bq_b[$];
    int unsigned dq_a[$];
    int unsigned dq_b[$];

    multi_byte_uart_tx #(
        .CLK_HZ(8), .BAUD(1), .NUM_BYTES(2), .STOP_BITS(1)
    ) dut_a (
        .clock(clk), .reset(rst), .start(start_a), .data(data_a),
        .ready(ready_a), .done(done_a), .q(q_a)
    );

    multi_byte_uart_tx #(
        .CLK_HZ(8), .BAUD(1), .NUM_BYTES(1), .STOP_BITS(2)
    ) dut_b (
        .clock(clk), .reset(rst), .start(start_b), .data(data_b),
        .ready(ready_b), .done(done_b), .q(q_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event required=no_event", name);
    endtask

    task automatic push_a(input logic [15:0] d);
        logic [7:0] b;
        for (int k = 1; k >= 0; k--) begin
            b = d[k*8 +: 8];
            bq_a.push_back(1'b0);
            for (int i = 0; i < 8; i++) bq_a.push_back(b[i]);
            if (PAR_ON) bq_a.push_back(^b);
            bq_a.push_back(1'b1);
        end
        dq_a.push_back(DONE_A);
    endtask

    task automatic push_b(input logic [7:0] b);
        bq_b.push_back(1'b0);
        for (int i = 0; i < 8; i++) bq_b.push_back(b[i]);
        if (PAR_ON) bq_b.push_back(^b);
        bq_b.push_back(1'b1);
        bq_b.push_back(1'b1);
        dq_b.push_back(DONE_B);
    endtask

    // Monitor: tracks each accepted transfer, samples q mid-bit, checks done timing.
    int unsigned per_a, per_b;
    bit act_a = 0, act_b = 0, rchk_a = 0, rchk_b = 0, rst_seen = 0;

    always @(negedge clk) begin
        if (rst) begin
            act_a = 0; act_b = 0; rchk_a = 0; rchk_b = 0;
            bq_a.delete(); dq_a.delete(); bq_b.delete(); dq_b.delete();
            rst_seen = 1;
        end else begin
            if (rst_seen) begin
                chk("rst_q_a", q_a, 1); chk("rst_ready_a", ready_a, 1); chk("rst_done_a", done_a, 0);
                chk("rst_q_b", q_b, 1); chk("rst_ready_b", ready_b, 1); chk("rst_done_b", done_b, 0);
                rst_seen = 0;
            end
            if (rchk_a) begin chk("ready_after_done_a", ready_a, 1); rchk_a = 0; end
            if (rchk_b) begin chk("ready_after_done_b", ready_b, 1); rchk_b = 0; end

            if (act_a) begin
                per_a++;
                if (per_a == 1) chk("busy_ready_a", ready_a, 0);
                if ((per_a - 1) % DIV == DIV / 2) begin
                    if (bq_a.size() == 0) fail_now("bit_a_extra");
                    else chk($sformatf("bit_a_p%0d", per_a), q_a, bq_a.pop_front());
                end
                if (done_a) begin
                    if (dq_a.size() == 0) fail_now("done_a_unexpected");
                    else chk("done_cycle_a", per_a, dq_a.pop_front());
                    act_a = 0; rchk_a = 1;
                end else if (per_a > 400) begin
                    fail_now("done_a_timeout"); act_a = 0;
                end
            end else if (done_a) fail_now("done_a_spurious");

            if (act_b) begin
                per_b++;
                if (per_b == 1) chk("busy_ready_b", ready_b, 0);
                if ((per_b - 1) % DIV == DIV / 2) begin
                    if (bq_b.size() == 0) fail_now("bit_b_extra");
                    else chk($sformatf("bit_b_p%0d", per_b), q_b, bq_b.pop_front());
                end
                if (done_b) begin
                    if (dq_b.size() == 0) fail_now("done_b_unexpected");
                    else chk("done_cycle_b", per_b, dq_b.pop_front());
                    act_b = 0; rchk_b = 1;
                end else if (per_b > 400) begin
                    fail_now("done_b_timeout"); act_b = 0;
                end
            end else if (done_b) fail_now("done_b_spurious");

            if (start_a && ready_a) begin act_a = 1; per_a = 0; end
            if (start_b && ready_b) begin act_b = 1; per_b = 0; end
        end
    end

    task automatic wait_idle_a();
        for (int i = 0; i < 1000 && !ready_a; i++) begin @(posedge clk); #1; end
        if (!ready_a) fail_now("ready_a_timeout");
    endtask

    task automatic wait_idle_b();
        for (int i = 0; i < 1000 && !ready_b; i++) begin @(posedge clk); #1; end
        if (!ready_b) fail_now("ready_b_timeout");
    endtask

    task automatic send_a(input logic [15:0] d, input bit hold);
        wait_idle_a();
        start_a = 1'b1; data_a = d;
        push_a(d);
        @(posedge clk); #1;
        data_a = ~d;
        if (!hold) start_a = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d);
        wait_idle_b();
        start_b = 1'b1; data_b = d;
        push_b(d);
        @(posedge clk); #1;
        data_b = ~d;
        start_b = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; data_a = '0; data_b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Pulsed start, data scrambled right after accept.
        send_a(16'hA55A, 1'b0);
        wait_idle_a();
        repeat (3) @(posedge clk);
        #1;

        // start held: exactly one extra transfer, taken when ready returns.
        send_a(16'h3C81, 1'b1);
        push_a(~16'h3C81);
        repeat (DONE_A + 1) @(posedge clk);
        #1 start_a = 1'b0;
        wait_idle_a();
        repeat (3) @(posedge clk);
        #1;

        // Reset in period 40 of a transfer; no done must follow.
        send_a(16'h0F0F, 1'b0);
        repeat (39) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (200) @(posedge clk);
        #1;

        // One byte, two stop bits.
        send_b(8'h00);
        wait_idle_b();
        send_b(8'h07);
        wait_idle_b();
        send_b(8'hC6);
        wait_idle_b();
        repeat (4) @(posedge clk);
        #1;

        if (bq_a.size() != 0 || dq_a.size() != 0) fail_now("leftover_a");
        if (bq_b.size() != 0 || dq_b.size() != 0) fail_now("leftover_b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
